uart_word_receiver: RTL and testbench
=====================================

# uart_word_receiver

Serial receive path that rebuilds the 32-bit words the debug unit sends out through `uart_32b` on the board's TX line. It sits on the host-facing end of that link, in test benches and in loop-back / board-to-board builds. It deserializes 8N1 UART frames with 16x oversampling and assembles four consecutive bytes, first received into bits [7:0], into one word. It reports frame errors and inter-byte timeouts, and discards partial words on either.

## Interface
- `NB_DATA`, 32, assembled word width; must equal 4·`NB_BYTE`
- `NB_BYTE`, 8, data bits per UART frame
- `BAUD_DIVISOR`, 326, clocks per oversample tick (50 MHz / (9600·16))
- `N_TICKS`, 16, oversample ticks per bit
- `TIMEOUT_CYCLES`, 200000, idle clocks allowed between bytes of one word
- `i_clock`  in  1  single clock (the divided system clock); all logic on rising edge
- `i_reset`  in  1  synchronous, active-low reset
- `i_rx`  in  1  serial line, idle high, asynchronous to `i_clock`
- `i_clear`  in  1  flush any partial word (byte counter to 0)
- `o_byte`  out  `NB_BYTE`  last good byte received
- `o_byte_valid`  out  1  one-cycle pulse, `o_byte` updated
- `o_word`  out  `NB_DATA`  last complete word; held until the next one
- `o_word_valid`  out  1  one-cycle pulse, `o_word` updated
- `o_frame_error`  out  1  one-cycle pulse, stop bit sampled low
- `o_timeout`  out  1  one-cycle pulse, partial word dropped on inter-byte timeout
- `o_busy`  out  1  high while in any state but IDLE or while a partial word is pending

## Operation
- Input: two-flop synchronizer on `i_rx`, both flops reset to 1. All decisions use the synchronized value.
- Tick generator: counter runs 0..`BAUD_DIVISOR`-1 and is free-running outside IDLE. The tick is high in the cycle the counter equals `BAUD_DIVISOR`-1. The counter is forced to 0 on the IDLE→START transition.
- Bit FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: synchronized rx = 0 → START, tick_count = 0.
  - START: on tick, increment tick_count. When tick_count reaches `N_TICKS`/2-1 (mid start bit), sample rx. If 0 → DATA, tick_count = 0, bit_count = 0. If 1 → glitch, return to IDLE with no output.
  - DATA: every `N_TICKS` ticks sample rx into the shift register, LSB first. After `NB_BYTE` samples → STOP.
  - STOP: after `N_TICKS` ticks sample rx. If 1 → byte good, return to IDLE. If 0 → frame error, go to WAIT_HIGH.
  - WAIT_HIGH: stays until synchronized rx = 1, then IDLE.
- Byte good: `o_byte` ← shift register; `o_byte_valid` pulses. The byte is written into word slot byte_count, giving bits [8·k+7:8·k]. byte_count increments.
  - On byte_count = 3, `o_word` ← assembled word, `o_word_valid` pulses together with `o_byte_valid`, and byte_count wraps to 0.
- Frame error: `o_frame_error` pulses, the byte is discarded, byte_count ← 0, and `o_byte`/`o_word` are left unchanged.
- Timeout: counter runs only while in IDLE with byte_count ≠ 0, and is cleared whenever the FSM leaves IDLE.
  - When it reaches `TIMEOUT_CYCLES`-1: byte_count ← 0 and `o_timeout` pulses.
- `i_clear`: byte_count ← 0 and timeout counter ← 0. It does not abort a frame in progress.
  - If `i_clear` coincides with a 4th good byte, clear wins: `o_byte_valid` pulses, `o_word_valid` does not, and `o_word` is unchanged.
  - `i_clear` coinciding with a timeout expiry gives no `o_timeout`.

## Timing
- Reset: every output is 0, FSM is in IDLE, all counters are 0, synchronizer flops are 1. Reset mid-frame abandons the frame and the partial word without pulsing anything.
- Start-edge detection latency is 2 clocks (synchronizer).
- A frame's `o_byte_valid` is registered. It is high in the clock after the stop-bit sample tick, for exactly 1 cycle.
- `o_word_valid`, `o_frame_error` and `o_timeout` are registered one-cycle pulses. They are never high in consecutive cycles.
- `o_frame_error` and `o_byte_valid` are mutually exclusive in the same cycle.
- Back-to-back frames: a start bit arriving in the clock after STOP→IDLE is accepted. There is no required idle gap beyond the stop bit.
- Tolerates ±3% baud mismatch; sampling is at mid-bit.

## Test plan
- **Word receive:** `BAUD_DIVISOR`=4 (64 clocks/bit). Send frames 0xEF, 0xBE, 0xAD, 0xDE back to back. Required:
  - 4 `o_byte_valid` pulses, with `o_byte` = EF, BE, AD, DE;
  - 1 `o_word_valid` pulse on the last, `o_word` = 0xDEADBEEF.
- **Start glitch:** drive rx low for 20 clocks, then high. No pulse on any output; FSM back in IDLE; then 4 bytes 11 22 33 44 → `o_word` = 0x44332211.
- **Frame error:** send 0x55 with stop bit 0, held low 200 clocks. Required:
  - `o_frame_error` pulses once;
  - `o_busy` stays high until the line rises;
  - a following 4-byte word assembles from byte 0.
- **Timeout:** `TIMEOUT_CYCLES`=1000. Send 0xAA, idle 1200 clocks. Required:
  - `o_timeout` pulses once, 1000 clocks after the byte;
  - next 4 bytes 01 02 03 04 → 0x04030201.
- **Clear collision:** assert `i_clear` in the same cycle as the 4th byte's completion. `o_byte_valid` pulses, `o_word_valid` stays 0, and `o_word` keeps its prior value.
- **Reset mid-frame:** pull `i_reset` low during DATA bit 3 of a frame and release it. Required:
  - all outputs 0;
  - FSM in IDLE;
  - the remaining bits of the interrupted frame produce no `o_byte_valid`, and at most one `o_frame_error`;
  - a fresh 4-byte word assembles correctly.

Source files
------------

// File: rtl/uart_word_receiver.sv
// uart_word_receiver
//   Receives 8N1 UART frames with 16x oversampling and packs four
//   consecutive good bytes (first byte into bits [7:0]) into one word.
//   A partial word is dropped on a frame error, on an inter-byte timeout
//   or on i_clear.
//
// Ports
//   i_clock        rising-edge clock
//   i_reset        synchronous, active-low reset
//   i_rx           serial line, idle high, asynchronous to i_clock
//   i_clear        flush the partial word (frame in flight continues)
//   o_byte         last good byte
//   o_byte_valid   1-cycle pulse, o_byte updated
//   o_word         last complete word, held until the next one
//   o_word_valid   1-cycle pulse, o_word updated
//   o_frame_error  1-cycle pulse, stop bit sampled low
//   o_timeout      1-cycle pulse, partial word dropped after idle timeout
//   o_busy         frame in progress or partial word pending
module uart_word_receiver #(
  parameter int NB_DATA        = 32,
  parameter int NB_BYTE        = 8,
  parameter int BAUD_DIVISOR   = 326,
  parameter int N_TICKS        = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  input  logic               i_clear,
  output logic [NB_BYTE-1:0] o_byte,
  output logic               o_byte_valid,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_word_valid,
  output logic               o_frame_error,
  output logic               o_timeout,
  output logic               o_busy
);

  localparam int NB_SLOTS = NB_DATA / NB_BYTE;
  localparam int SLOT_W   = (NB_SLOTS > 1) ? $clog2(NB_SLOTS) : 1;
  localparam int BAUD_W   = (BAUD_DIVISOR > 1) ? $clog2(BAUD_DIVISOR) : 1;
  localparam int TICK_W   = $clog2(N_TICKS);
  localparam int BIT_W    = $clog2(NB_BYTE);
  localparam int TO_W     = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  logic               rx_p0;
  logic               rx_p1;
  state_t             state;
  state_t             state_next;
  logic [BAUD_W-1:0]  baud_cnt;
  logic               tick;
  logic [TICK_W-1:0]  tick_cnt;
  logic [TICK_W-1:0]  tick_cnt_next;
  logic [BIT_W-1:0]   bit_cnt;
  logic [BIT_W-1:0]   bit_cnt_next;
  logic               shift_en;
  logic               byte_done;
  logic               frame_err;
  logic [NB_BYTE-1:0] shift_reg;
  logic [SLOT_W-1:0]  byte_cnt;
  logic               last_slot;
  logic [TO_W-1:0]    to_cnt;
  logic               to_expire;
  logic [NB_DATA-1:0] word_buf;
  logic [NB_DATA-1:0] word_next;
  logic               word_commit;

  // ---- stage p0/p1: line synchronizer (idle level is 1) ----
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= i_rx;
      rx_p1 <= rx_p0;
    end
  end

  // ---- oversample tick generator ----
  // Held at 0 in IDLE so the first tick of a frame lands a full divisor
  // period after the start edge is seen.
  always_ff @(posedge i_clock) begin
    if (!i_reset || state == ST_IDLE || tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  assign tick = (baud_cnt == BAUD_W'(BAUD_DIVISOR - 1));

  // ---- bit-level FSM ----
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_next;
      tick_cnt <= tick_cnt_next;
      bit_cnt  <= bit_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    tick_cnt_next = tick_cnt;
    bit_cnt_next  = bit_cnt;
    shift_en      = 1'b0;
    byte_done     = 1'b0;
    frame_err     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_p1) begin
          state_next    = ST_START;
          tick_cnt_next = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          // Half a bit in: a line that is high again was only a glitch.
          if (tick_cnt == TICK_W'(N_TICKS / 2 - 1)) begin
            if (!rx_p1) begin
              state_next    = ST_DATA;
              tick_cnt_next = '0;
              bit_cnt_next  = '0;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tick_cnt == TICK_W'(N_TICKS - 1)) begin
            tick_cnt_next = '0;
            shift_en      = 1'b1;
            bit_cnt_next  = bit_cnt + 1'b1;
            if (bit_cnt == BIT_W'(NB_BYTE - 1)) begin
              state_next = ST_STOP;
            end
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (tick_cnt == TICK_W'(N_TICKS - 1)) begin
            tick_cnt_next = '0;
            if (rx_p1) begin
              byte_done  = 1'b1;
              state_next = ST_IDLE;
            end else begin
              frame_err  = 1'b1;
              state_next = ST_WAIT_HIGH;
            end
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // A stuck-low line must not be mistaken for a new start bit.
        if (rx_p1) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---- data shift register, LSB first ----
  always_ff @(posedge i_clock) begin
    if (shift_en) begin
      shift_reg <= {rx_p1, shift_reg[NB_BYTE-1:1]};
    end
  end

  // ---- word assembly ----
  always_comb begin
    word_next = word_buf;
    word_next[byte_cnt * NB_BYTE +: NB_BYTE] = shift_reg;
  end

  always_ff @(posedge i_clock) begin
    if (byte_done) begin
      word_buf <= word_next;
    end
  end

  assign last_slot   = (byte_cnt == SLOT_W'(NB_SLOTS - 1));
  // i_clear in the completion cycle discards the word being finished.
  assign word_commit = byte_done && last_slot && !i_clear;
  assign to_expire   = (state == ST_IDLE) && (byte_cnt != '0) &&
                       (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // ---- output stage: registered pulses, byte counter, timeout ----
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      o_byte        <= '0;
      o_byte_valid  <= 1'b0;
      o_word        <= '0;
      o_word_valid  <= 1'b0;
      o_frame_error <= 1'b0;
      o_timeout     <= 1'b0;
      byte_cnt      <= '0;
      to_cnt        <= '0;
    end else begin
      o_byte_valid  <= byte_done;
      o_word_valid  <= word_commit;
      o_frame_error <= frame_err;
      o_timeout     <= to_expire && !i_clear;
      if (byte_done) begin
        o_byte <= shift_reg;
      end
      if (word_commit) begin
        o_word <= word_next;
      end
      if (i_clear || frame_err || to_expire) begin
        byte_cnt <= '0;
      end else if (byte_done) begin
        byte_cnt <= last_slot ? '0 : byte_cnt + 1'b1;
      end
      // Counts idle clocks only while a partial word is waiting.
      if (i_clear || state != ST_IDLE || byte_cnt == '0 || to_expire) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  assign o_busy = (state != ST_IDLE) || (byte_cnt != '0);

endmodule

// File: tb/tb_uart_word_receiver.sv
module tb_uart_word_receiver;

  localparam int NB_DATA        = 32;
  localparam int NB_BYTE        = 8;
  localparam int BAUD_DIVISOR   = 4;
  localparam int N_TICKS        = 16;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int CPB            = BAUD_DIVISOR * N_TICKS;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic               rx    = 1'b1;
  logic               clr   = 1'b0;
  logic [NB_BYTE-1:0] o_byte;
  logic               o_byte_valid;
  logic [NB_DATA-1:0] o_word;
  logic               o_word_valid;
  logic               o_frame_error;
  logic               o_timeout;
  logic               o_busy;

  uart_word_receiver #(
    .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .BAUD_DIVISOR(BAUD_DIVISOR),
    .N_TICKS(N_TICKS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .i_clock(clk), .i_reset(rst_n), .i_rx(rx), .i_clear(clr),
    .o_byte(o_byte), .o_byte_valid(o_byte_valid),
    .o_word(o_word), .o_word_valid(o_word_valid),
    .o_frame_error(o_frame_error), .o_timeout(o_timeout), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: expected bytes in send order, word slots, held outputs
  logic [7:0]  byte_q[$];
  logic [7:0]  m_slots[0:3];
  int          m_count = 0;
  logic [31:0] m_word  = '0;
  logic [7:0]  m_byte  = '0;
  int          last_start  = 0;
  int          last_bv_cyc = 0;
  int          n_bv = 0, n_wv = 0, n_fe = 0, n_to = 0;

  initial begin
    logic rst_e, clr_e, prev_wv, prev_fe, prev_to, exp_wv;
    logic [7:0] b;
    int lat;
    rst_e = 1'b0; clr_e = 1'b0;
    prev_wv = 1'b0; prev_fe = 1'b0; prev_to = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_e) begin
        m_count = 0; m_word = '0; m_byte = '0;
        byte_q.delete();
        check("reset_pulses_busy", {27'd0, o_byte_valid, o_word_valid, o_frame_error, o_timeout, o_busy}, 32'd0);
        check("reset_byte", {24'd0, o_byte}, 32'd0);
        check("reset_word", o_word, 32'd0);
      end else begin
        if (o_byte_valid) begin
          n_bv++;
          b = 8'h00;
          if (byte_q.size() == 0) begin
            failures++; checks++;
            $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)", o_byte, cyc);
          end else begin
            b = byte_q.pop_front();
            check("byte_value", {24'd0, o_byte}, {24'd0, b});
          end
          m_byte = b;
          lat = cyc - last_start;
          checks++;
          if (lat < 605 || lat > 617) begin
            failures++;
            $display("FAIL byte_latency: got %0d cycles expected 605..617", lat);
          end
          last_bv_cyc = cyc;
          exp_wv = !clr_e && (m_count == 3);
          m_slots[m_count] = b;
          if (exp_wv) m_word = {m_slots[3], m_slots[2], m_slots[1], m_slots[0]};
          m_count = (clr_e || m_count == 3) ? 0 : m_count + 1;
          check("word_valid_with_byte", {31'd0, o_word_valid}, {31'd0, exp_wv});
          check("frame_error_excl", {31'd0, o_frame_error}, 32'd0);
        end else begin
          check("word_valid_alone", {31'd0, o_word_valid}, 32'd0);
          if (o_frame_error) begin
            n_fe++;
            m_count = 0;
          end
          if (o_timeout) begin
            n_to++;
            check("timeout_pending", {31'd0, m_count != 0}, 32'd1);
            check("timeout_delay", cyc - last_bv_cyc, TIMEOUT_CYCLES);
            m_count = 0;
          end
          if (clr_e) m_count = 0;
        end
        if (o_word_valid) n_wv++;
        check("word_hold", o_word, m_word);
        check("byte_hold", {24'd0, o_byte}, {24'd0, m_byte});
        check("no_double_pulse", {31'd0, (o_word_valid && prev_wv) || (o_frame_error && prev_fe) ||
                                         (o_timeout && prev_to)}, 32'd0);
      end
      prev_wv = o_word_valid; prev_fe = o_frame_error; prev_to = o_timeout;
      rst_e = rst_n; clr_e = clr;
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    last_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic send_good(input logic [7:0] b);
    byte_q.push_back(b);
    send_frame(b, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_good(w[8*i +: 8]);
  endtask

  initial begin
    int bv0, wv0, fe0, to0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_busy", {31'd0, o_busy}, 32'd0);

    // Word receive: EF BE AD DE
    bv0 = n_bv; wv0 = n_wv;
    send_word(32'hDEADBEEF);
    repeat (20) @(posedge clk);
    #1;
    check("word1_value", o_word, 32'hDEADBEEF);
    check("word1_bytes", n_bv - bv0, 4);
    check("word1_words", n_wv - wv0, 1);
    check("word1_last_byte", {24'd0, o_byte}, 32'hDE);

    // Start glitch
    bv0 = n_bv; wv0 = n_wv; fe0 = n_fe; to0 = n_to;
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("glitch_busy", {31'd0, o_busy}, 32'd0);
    check("glitch_no_pulses", (n_bv - bv0) + (n_wv - wv0) + (n_fe - fe0) + (n_to - to0), 0);
    send_word(32'h44332211);
    repeat (20) @(posedge clk);
    #1;
    check("word2_value", o_word, 32'h44332211);

    // Frame error with a pending partial word
    send_good(8'h99);
    bv0 = n_bv; fe0 = n_fe;
    last_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
    rx = 1'b0;
    repeat (190) @(posedge clk);
    #1;
    check("ferr_busy_low_line", {31'd0, o_busy}, 32'd1);
    check("ferr_count", n_fe - fe0, 1);
    repeat (10) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("ferr_busy_after_rise", {31'd0, o_busy}, 32'd0);
    check("ferr_no_byte", n_bv - bv0, 0);
    check("ferr_word_kept", o_word, 32'h44332211);
    send_word(32'h78563412);
    repeat (20) @(posedge clk);
    #1;
    check("word3_value", o_word, 32'h78563412);

    // Inter-byte timeout
    to0 = n_to;
    send_good(8'hAA);
    check("timeout_busy_pending", {31'd0, o_busy}, 32'd1);
    repeat (1200) @(posedge clk);
    #1;
    check("timeout_count", n_to - to0, 1);
    check("timeout_busy_after", {31'd0, o_busy}, 32'd0);
    send_word(32'h04030201);
    repeat (20) @(posedge clk);
    #1;
    check("word4_value", o_word, 32'h04030201);

    // Clear coinciding with the fourth byte
    bv0 = n_bv; wv0 = n_wv;
    send_good(8'hA1);
    send_good(8'hB2);
    send_good(8'hC3);
    fork
      send_good(8'hD4);
      begin
        repeat (600) @(posedge clk);
        #1;
        clr = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        clr = 1'b0;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    check("clear_bytes", n_bv - bv0, 4);
    check("clear_no_word", n_wv - wv0, 0);
    check("clear_word_kept", o_word, 32'h04030201);
    check("clear_busy", {31'd0, o_busy}, 32'd0);
    send_word(32'h40302010);
    repeat (20) @(posedge clk);
    #1;
    check("word5_value", o_word, 32'h40302010);

    // Reset during data bit 3 of 0xFA, with a partial word pending
    send_good(8'h5A);
    bv0 = n_bv; fe0 = n_fe;
    last_start = cyc;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midreset_word", o_word, 32'd0);
    check("midreset_busy", {31'd0, o_busy}, 32'd0);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    repeat (50) @(posedge clk);
    #1;
    check("midreset_no_byte", n_bv - bv0, 0);
    check("midreset_ferr_le1", {31'd0, (n_fe - fe0) <= 1}, 32'd1);
    check("midreset_idle", {31'd0, o_busy}, 32'd0);
    send_word(32'h01EEFFC0);
    repeat (20) @(posedge clk);
    #1;
    check("word6_value", o_word, 32'h01EEFFC0);
    check("queue_drained", byte_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
